cache_mem_arbiter: RTL

- Shares the single downstream memory port between the instruction cache and the data cache.
- Both caches use the same request/done protocol: req held high until a one-cycle dok.
- The arbiter grants one requester at a time and converts the transfer into an address/data two-phase downstream handshake.
- It returns read data and dok only to the granted requester.

---
 rtl/cache_mem_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one downstream memory port between the I-cache and D-cache,
// using an address/data two-phase handshake and returning data/dok to the granted requester.
module cache_mem_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_cache_req,
    input  logic [31:0] inst_cache_addr,
    output logic [31:0] inst_cache_rdata,
    output logic        inst_cache_dok,
    input  logic        data_cache_req,
    input  logic        data_cache_wr,
    input  logic [31:0] data_cache_addr,
    input  logic [31:0] data_cache_wdata,
    output logic [31:0] data_cache_rdata,
    output logic        data_cache_dok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state;
    logic        gnt_d;
    logic        last_d;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        pick_d;

    // last_d == 0 means the I-cache was served last, so D wins a round-robin tie.
    always_comb pick_d = data_cache_req && (!inst_cache_req || PRIO_MODE != 0 || !last_d);

    assign mem_size         = 2'b10;
    assign mem_addr         = addr_q;
    assign mem_wr           = wr_q;
    assign mem_wdata        = wdata_q;
    assign inst_cache_rdata = rdata_q;
    assign data_cache_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            gnt_d          <= 1'b0;
            last_d         <= 1'b0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            mem_req        <= 1'b0;
            inst_cache_dok <= 1'b0;
            data_cache_dok <= 1'b0;
        end else begin
            inst_cache_dok <= 1'b0;
            data_cache_dok <= 1'b0;
            case (state)
                IDLE: if (inst_cache_req || data_cache_req) begin
                    gnt_d   <= pick_d;
                    addr_q  <= pick_d ? data_cache_addr : inst_cache_addr;
                    wr_q    <= pick_d && data_cache_wr;
                    wdata_q <= pick_d ? data_cache_wdata : 32'h0;
                    mem_req <= 1'b1;
                    state   <= ADDR;
                end
                ADDR: if (mem_addr_ok) begin
                    mem_req <= 1'b0;
                    if (mem_data_ok) begin
                        rdata_q        <= mem_rdata;
                        inst_cache_dok <= !gnt_d;
                        data_cache_dok <= gnt_d;
                        state          <= RESP;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (mem_data_ok) begin
                    rdata_q        <= mem_rdata;
                    inst_cache_dok <= !gnt_d;
                    data_cache_dok <= gnt_d;
                    state          <= RESP;
                end
                RESP: begin
                    last_d <= gnt_d;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
